// File: rtl/wb_trace_buffer.sv
// Write-event trace FIFO: captures GRF writes and DM stores from the core and
// drains them first-word-fall-through over a valid/ready port.
module wb_trace_buffer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          grf_we,
  input  logic [31:0]   grf_pc,
  input  logic [4:0]    grf_addr,
  input  logic [31:0]   grf_wdata,
  input  logic          dm_we,
  input  logic [31:0]   dm_pc,
  input  logic [31:0]   dm_addr,
  input  logic [31:0]   dm_wdata,
  output logic          tr_valid,
  input  logic          tr_ready,
  output logic          tr_kind,
  output logic [31:0]   tr_pc,
  output logic [31:0]   tr_addr,
  output logic [31:0]   tr_data,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [15:0]   drop_cnt
);

  // Handshake: the head entry transfers on a rising edge where tr_valid and
  // tr_ready are both 1; while tr_valid is 1 and tr_ready is 0 the head holds.

  typedef struct packed {
    logic        kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] dm_slot;

  logic          grf_ev;
  logic          dm_ev;
  logic          pop;
  logic          grf_acc;
  logic          dm_acc;
  logic [AW+1:0] free_slots;
  logic [AW+1:0] dm_need;
  logic [1:0]    n_push;
  logic [1:0]    n_drop;
  logic [16:0]   drop_sum;
  entry_t        grf_entry;
  entry_t        dm_entry;
  entry_t        head;

  always_comb begin
    grf_ev     = grf_we && (grf_addr != 5'd0);
    dm_ev      = dm_we;
    pop        = tr_valid && tr_ready;
    // A pop this cycle frees its slot for same-cycle pushes.
    free_slots = DEPTH_W - {1'b0, count} + {{(AW+1){1'b0}}, pop};
    grf_acc    = grf_ev && (free_slots != '0);
    dm_need    = grf_acc ? (AW+2)'(2) : (AW+2)'(1);
    dm_acc     = dm_ev && (free_slots >= dm_need);
    n_push     = {1'b0, grf_acc} + {1'b0, dm_acc};
    n_drop     = {1'b0, grf_ev & ~grf_acc} + {1'b0, dm_ev & ~dm_acc};
    drop_sum   = {1'b0, drop_cnt} + {15'b0, n_drop};
    // The GRF entry is older, so the DM entry lands one slot behind it.
    dm_slot    = grf_acc ? (wr_ptr + AW'(1)) : wr_ptr;

    grf_entry.kind = 1'b0;
    grf_entry.pc   = grf_pc;
    grf_entry.addr = {27'b0, grf_addr};
    grf_entry.data = grf_wdata;

    dm_entry.kind  = 1'b1;
    dm_entry.pc    = dm_pc;
    dm_entry.addr  = dm_addr;
    dm_entry.data  = dm_wdata;
  end

  // Storage needs no reset: nothing is visible until count says it is valid.
  always_ff @(posedge clk) begin
    if (grf_acc) mem[wr_ptr] <= grf_entry;
    if (dm_acc)  mem[dm_slot] <= dm_entry;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(n_push);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(n_push) - (AW+1)'(pop);
      if (n_drop != 2'd0) begin
        overflow <= 1'b1;
        drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
    end
  end

  always_comb begin
    head     = mem[rd_ptr];
    tr_valid = (count != '0);
    tr_kind  = tr_valid ? head.kind : 1'b0;
    tr_pc    = tr_valid ? head.pc   : 32'h0;
    tr_addr  = tr_valid ? head.addr : 32'h0;
    tr_data  = tr_valid ? head.data : 32'h0;
  end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer: a directed vector table followed by
// hand-written overflow, full-throughput, saturation and mid-run reset sequences.
module tb_wb_trace_buffer;

  logic        clk;
  logic        reset;
  logic        grf_we;
  logic [31:0] grf_pc;
  logic [4:0]  grf_addr;
  logic [31:0] grf_wdata;
  logic        dm_we;
  logic [31:0] dm_pc;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        tr_valid;
  logic        tr_ready;
  logic        tr_kind;
  logic [31:0] tr_pc;
  logic [31:0] tr_addr;
  logic [31:0] tr_data;
  logic [3:0]  count;
  logic        overflow;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  logic [96:0] exp_q[$];

  wb_trace_buffer #(.DEPTH(8), .AW(3)) dut (
    .clk(clk), .reset(reset),
    .grf_we(grf_we), .grf_pc(grf_pc), .grf_addr(grf_addr), .grf_wdata(grf_wdata),
    .dm_we(dm_we), .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_kind(tr_kind),
    .tr_pc(tr_pc), .tr_addr(tr_addr), .tr_data(tr_data),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        gwe;
    logic [31:0] gpc;
    logic [4:0]  ga;
    logic [31:0] gd;
    logic        dwe;
    logic [31:0] dpc;
    logic [31:0] da;
    logic [31:0] dd;
    logic        rdy;
    logic        ev;
    logic [96:0] eh;
    logic [3:0]  ec;
    logic        eo;
    logic [15:0] edr;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [96:0] ge(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d);
    return {1'b0, pc, 27'b0, a, d};
  endfunction

  function automatic logic [96:0] de(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] d);
    return {1'b1, pc, a, d};
  endfunction

  function automatic logic [96:0] head();
    return {tr_kind, tr_pc, tr_addr, tr_data};
  endfunction

  function automatic vec_t mk(input logic gwe, input logic [31:0] gpc, input logic [4:0] ga,
                              input logic [31:0] gd, input logic dwe, input logic [31:0] dpc,
                              input logic [31:0] da, input logic [31:0] dd, input logic rdy,
                              input logic ev, input logic [96:0] eh, input logic [3:0] ec);
    vec_t v;
    v.gwe = gwe; v.gpc = gpc; v.ga = ga; v.gd = gd;
    v.dwe = dwe; v.dpc = dpc; v.da = da; v.dd = dd;
    v.rdy = rdy; v.ev = ev; v.eh = eh; v.ec = ec;
    v.eo = 1'b0; v.edr = 16'd0;
    return v;
  endfunction

  // Driver tasks
  task automatic set_idle();
    grf_we = 0; grf_pc = 0; grf_addr = 0; grf_wdata = 0;
    dm_we = 0; dm_pc = 0; dm_addr = 0; dm_wdata = 0;
    tr_ready = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_grf(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d);
    grf_we = 1; grf_pc = pc; grf_addr = a; grf_wdata = d;
  endtask

  task automatic drive_dm(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] d);
    dm_we = 1; dm_pc = pc; dm_addr = a; dm_wdata = d;
  endtask

  // Scoreboard compare
  task automatic check(input string name, input logic [96:0] act, input logic [96:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Pop one entry while checking it against the expected queue front.
  task automatic drain_one(input string name);
    logic [96:0] e;
    e = exp_q.pop_front();
    check(name, head(), e);
    tr_ready = 1;
    tick();
    tr_ready = 0;
  endtask

  initial begin
    set_idle();
    reset = 0;

    // Reset held: outputs stay zero regardless of input activity.
    for (int i = 0; i < 5; i++) begin
      grf_we = 1'($urandom_range(0, 1)); grf_addr = 5'($urandom_range(1, 31));
      grf_pc = $urandom; grf_wdata = $urandom;
      dm_we = 1'($urandom_range(0, 1)); dm_pc = $urandom; dm_addr = $urandom; dm_wdata = $urandom;
      tr_ready = 1'($urandom_range(0, 1));
      tick();
      check("reset_outputs", {tr_valid, head(), count, overflow, drop_cnt}, '0);
    end
    set_idle();
    reset = 1;
    repeat (10) tick();
    check("idle_valid", 97'(tr_valid), 97'(0));
    check("idle_count", 97'(count), 97'(0));

    // Vector table: inputs for one edge, then expected state after that edge.
    vecs[0]  = mk(1, 32'h3000, 5'd8, 32'h1234_5678, 0, 0, 0, 0, 0,
                  1, ge(32'h3000, 5'd8, 32'h1234_5678), 4'd1);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,
                  1, ge(32'h3000, 5'd8, 32'h1234_5678), 4'd1);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, '0, 4'd0);
    vecs[3]  = mk(1, 32'h3000, 5'd0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, '0, 4'd0);
    vecs[4]  = mk(1, 32'h3004, 5'd9, 32'h1, 1, 32'h3004, 32'h10, 32'h2, 0,
                  1, ge(32'h3004, 5'd9, 32'h1), 4'd2);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1,
                  1, de(32'h3004, 32'h10, 32'h2), 4'd1);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, '0, 4'd0);
    vecs[7]  = mk(0, 0, 0, 0, 1, 32'h3008, 32'h20, 32'hDEAD, 1,
                  1, de(32'h3008, 32'h20, 32'hDEAD), 4'd1);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, '0, 4'd0);
    vecs[9]  = mk(1, 32'h300C, 5'd31, 32'hAAAA_5555, 0, 0, 0, 0, 0,
                  1, ge(32'h300C, 5'd31, 32'hAAAA_5555), 4'd1);
    vecs[10] = mk(0, 0, 0, 0, 1, 32'h3010, 32'h24, 32'h7, 1,
                  1, de(32'h3010, 32'h24, 32'h7), 4'd1);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, '0, 4'd0);

    for (int i = 0; i < 12; i++) begin
      grf_we = vecs[i].gwe; grf_pc = vecs[i].gpc; grf_addr = vecs[i].ga; grf_wdata = vecs[i].gd;
      dm_we = vecs[i].dwe; dm_pc = vecs[i].dpc; dm_addr = vecs[i].da; dm_wdata = vecs[i].dd;
      tr_ready = vecs[i].rdy;
      tick();
      set_idle();
      check($sformatf("vec%0d_valid", i), 97'(tr_valid), 97'(vecs[i].ev));
      check($sformatf("vec%0d_head", i), head(), vecs[i].eh);
      check($sformatf("vec%0d_count", i), 97'(count), 97'(vecs[i].ec));
      check($sformatf("vec%0d_drop", i), 97'({overflow, drop_cnt}), 97'({vecs[i].eo, vecs[i].edr}));
    end

    // Overflow: ten writes into eight slots with the sink stalled.
    for (int i = 0; i < 10; i++) begin
      drive_grf(32'h4000 + 32'(i * 4), 5'(i + 1), 32'(i * 32'h11));
      if (i < 8) exp_q.push_back(ge(32'h4000 + 32'(i * 4), 5'(i + 1), 32'(i * 32'h11)));
      tick();
    end
    set_idle();
    check("ovf_count", 97'(count), 97'(8));
    check("ovf_flag", 97'(overflow), 97'(1));
    check("ovf_drop", 97'(drop_cnt), 97'(2));
    for (int i = 0; i < 8; i++) drain_one($sformatf("ovf_drain%0d", i));
    check("ovf_empty", 97'(count), 97'(0));

    // Seven held plus a dual event: GRF takes the last slot, DM is dropped.
    for (int i = 0; i < 7; i++) begin
      drive_dm(32'h4100 + 32'(i * 4), 32'h100 + 32'(i * 4), 32'($urandom));
      exp_q.push_back(de(dm_pc, dm_addr, dm_wdata));
      tick();
    end
    drive_grf(32'h4200, 5'd12, 32'hCAFE_0001);
    drive_dm(32'h4200, 32'h200, 32'hCAFE_0002);
    exp_q.push_back(ge(32'h4200, 5'd12, 32'hCAFE_0001));
    tick();
    set_idle();
    check("dual7_count", 97'(count), 97'(8));
    check("dual7_drop", 97'(drop_cnt), 97'(3));

    // Full FIFO with a pop and a push every cycle, across pointer wrap.
    for (int i = 0; i < 20; i++) begin
      check($sformatf("full_head%0d", i), head(), exp_q[0]);
      if (i % 2 == 0) begin
        drive_grf(32'h5000 + 32'(i * 4), 5'(i + 1), 32'(i) ^ 32'h5A5A_0000);
        exp_q.push_back(ge(grf_pc, grf_addr, grf_wdata));
      end else begin
        drive_dm(32'h5000 + 32'(i * 4), 32'h300 + 32'(i * 4), 32'(i) ^ 32'hA5A5_0000);
        exp_q.push_back(de(dm_pc, dm_addr, dm_wdata));
      end
      tr_ready = 1;
      tick();
      set_idle();
      void'(exp_q.pop_front());
      check($sformatf("full_count%0d", i), 97'(count), 97'(8));
    end
    check("full_drop", 97'(drop_cnt), 97'(3));

    // Saturation: dual drops while full, drop_cnt must stop at FFFF.
    drive_grf(32'h6000, 5'd1, 32'h1);
    drive_dm(32'h6000, 32'h400, 32'h2);
    repeat (32765) tick();
    check("sat_below", 97'(drop_cnt), 97'(16'hFFFD));
    tick();
    check("sat_exact", 97'(drop_cnt), 97'(16'hFFFF));
    tick();
    set_idle();
    check("sat_hold", 97'(drop_cnt), 97'(16'hFFFF));
    check("sat_count", 97'(count), 97'(8));

    for (int i = 0; i < 3; i++) drain_one($sformatf("sat_drain%0d", i));
    check("pre_reset_count", 97'(count), 97'(5));

    // Asynchronous reset between edges with five entries held.
    reset = 0;
    #2;
    check("async_reset", {tr_valid, head(), count, overflow, drop_cnt}, '0);
    #1;
    reset = 1;
    exp_q.delete();
    drive_grf(32'h7000, 5'd3, 32'h33);
    tick();
    set_idle();
    check("post_reset_count", 97'(count), 97'(1));
    check("post_reset_head", head(), ge(32'h7000, 5'd3, 32'h33));
    check("post_reset_ovf", 97'({overflow, drop_cnt}), 97'(0));
    tr_ready = 1;
    tick();
    set_idle();
    check("post_reset_empty", 97'({tr_valid, count}), 97'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_trace_buffer.md
# wb_trace_buffer

Captures architectural write events from the MIPS core (GRF register writes and DM stores) into a small FIFO and drains them one entry at a time over a valid/ready port to a trace sink (UART framer, compare unit, or bench). It sits beside the core, reading the same write strobes the core drives into the GRF and DM, so a write trace can be checked against a golden model without `$display`.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, 2..64.
- `AW`, 3: log2(`DEPTH`).
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately.
- `grf_we`  in  1  core register-file write strobe this cycle.
- `grf_pc`  in  32  PC of the instruction performing the GRF write.
- `grf_addr`  in  5  destination register number.
- `grf_wdata`  in  32  value written.
- `dm_we`  in  1  core data-memory store strobe this cycle.
- `dm_pc`  in  32  PC of the store instruction.
- `dm_addr`  in  32  byte address stored to.
- `dm_wdata`  in  32  value stored.
- `tr_valid`  out  1  head entry available.
- `tr_ready`  in  1  sink accepts head entry this cycle.
- `tr_kind`  out  1  0 = GRF write, 1 = DM store.
- `tr_pc`  out  32  head entry PC.
- `tr_addr`  out  32  GRF: `{27'b0, grf_addr}`; DM: `dm_addr`.
- `tr_data`  out  32  head entry write data.
- `count`  out  AW+1  entries currently held, 0..`DEPTH`.
- `overflow`  out  1  sticky: at least one event dropped since reset.
- `drop_cnt`  out  16  events dropped since reset, saturating at 16'hFFFF.

## Operation
- Event qualification, sampled on each rising edge: GRF event = `grf_we && grf_addr != 0` (writes to $0 are never recorded); DM event = `dm_we`.
- Entry = {kind, pc, addr, data}; 97 bits.
- Pop = `tr_valid && tr_ready`; removes head entry.
- Free space this cycle = `DEPTH - count + pop`; a pop frees its slot for same-cycle pushes.
- Both events same cycle: GRF entry enqueued first (older), DM entry second. Space 1 -> GRF accepted, DM dropped. Space 0 -> both dropped.
- Each dropped event: `overflow` <= 1, `drop_cnt` += 1 (+2 when both dropped), saturating at 16'hFFFF, never wrapping.
- Storage: circular buffer, write and read pointers AW bits, wrap from `DEPTH-1` to 0; `count` tracked explicitly (full = `count == DEPTH`).
- Output is first-word-fall-through: `tr_kind/pc/addr/data` show head entry whenever `tr_valid`; driven all-zero when `tr_valid` = 0.
- Head fields stable while `tr_valid && !tr_ready`.
- `count` next = `count + pushes - pop`, pushes in {0,1,2}.
- `overflow` and `drop_cnt` clear only on reset.

## Timing
- Reset (`reset` = 0, asynchronous): `tr_valid` 0, `tr_kind/pc/addr/data` 0, `count` 0, `overflow` 0, `drop_cnt` 0, pointers 0. Events in flight are discarded; no partial entry survives.
- Reset release synchronous to design usage; first event sampled on first rising edge with `reset` = 1.
- Latency: event sampled at edge N -> `tr_valid` 1 and fields valid after edge N (empty FIFO case).
- Throughput: one pop per cycle; up to two pushes per cycle.
- Full FIFO with `tr_ready` = 1 and one event same cycle: pop and push both occur, `count` stays `DEPTH`, nothing dropped.
- Empty FIFO, `tr_ready` = 1, event arrives: entry not popped that edge (nothing valid yet); popped no earlier than the next edge.

## Test plan
- Reset/idle: hold `reset` = 0, toggle all inputs -> all outputs 0; release, no strobes for 10 cycles -> `tr_valid` 0, `count` 0.
- Single GRF write: `grf_we`=1, pc 32'h0000_3000, addr 8, data 32'h1234_5678 for one cycle, `tr_ready`=0 -> next cycle `tr_valid`=1, kind 0, `tr_addr`=32'h8, `count`=1; assert `tr_ready` -> entry popped, `count`=0. Repeat with addr 0 -> nothing enqueued.
- Dual event: same cycle GRF (pc 3004, $9 <= 1) and DM (pc 3004, addr 0x10, data 2) -> two entries, GRF popped first, then DM with kind 1.
- Overflow: `DEPTH`=8, `tr_ready`=0, 10 single GRF writes -> `count`=8, `overflow`=1, `drop_cnt`=2; drained order = first 8 events; dual event when 7 held -> GRF kept, `drop_cnt`+1.
- Full with simultaneous pop/push: fill 8, then `tr_ready`=1 plus one event each cycle for 20 cycles -> `count` stays 8, `drop_cnt` unchanged, output order matches input order across pointer wrap.
- Reset mid-operation: 5 entries held, `overflow`=1, pulse `reset` low between edges -> outputs 0 immediately; after release, new event appears as sole entry.
